// File: rtl/jk_pkg.sv
// Shared types for the JK command sequencer: operation encoding, FSM state and
// the JK next-state rule used to predict the downstream flip-flop.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  typedef logic [0:0] seq_state_t;

  localparam seq_state_t ST_IDLE = 1'b0;
  localparam seq_state_t ST_RUN  = 1'b1;

  // Queued command payload is {op, len}.
  localparam int CMD_W = 6;

  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    logic nq;
    nq = q;
    case (jk)
      2'b01:   nq = 1'b0;
      2'b10:   nq = 1'b1;
      2'b11:   nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO holding {op,len}; flush empties it on the next edge
// and discards any push offered on that edge.
module jk_cmd_fifo
  import jk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [CMD_W-1:0]         push_data,
  input  logic                     pop,
  output logic [CMD_W-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push & ~full & ~flush;
  assign pop_ok   = pop & ~empty & ~flush;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues JK commands and drives j/k for len+1 cycles each, back to back,
// while tracking the predicted state of the downstream JK flip-flop.
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [3:0]             cmd_len,
  input  logic                   flush,
  output logic                   j,
  output logic                   k,
  output logic                   busy,
  output logic                   done,
  output logic                   q_model,
  output logic [$clog2(DEPTH):0] level
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; the master holds cmd_op/cmd_len until then.
  // cmd_ready depends only on FIFO occupancy and flush, never on this cycle's pop.

  seq_state_t         state;
  jk_op_e             op_r;
  logic [3:0]         count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               last;
  logic [CMD_W-1:0]   head;

  assign cmd_ready = ~full & ~flush;
  assign push      = cmd_valid & cmd_ready;
  assign last      = (state == ST_RUN) && (count == 4'd0);
  assign pop       = ~flush & ~empty & ((state == ST_IDLE) | last);

  assign busy = (state == ST_RUN);
  assign j    = busy & op_r[1];
  assign k    = busy & op_r[0];

  jk_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data ({cmd_op, cmd_len}),
    .pop       (pop),
    .pop_data  (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_r    <= JK_HOLD;
      count   <= 4'd0;
      done    <= 1'b0;
      q_model <= 1'b0;
    end else begin
      // The prediction follows whatever j/k are on the wire, flush or not.
      q_model <= jk_next(q_model, {j, k});
      done    <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        count <= 4'd0;
      end else if (pop) begin
        state <= ST_RUN;
        op_r  <= jk_op_e'(head[5:4]);
        count <= head[3:0];
        done  <= last;
      end else if (last) begin
        state <= ST_IDLE;
        done  <= 1'b1;
      end else if (state == ST_RUN) begin
        count <= count - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: directed scenarios plus random traffic, all
// checked each cycle against a queue-based command model and a reference JK flop.
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic [3:0]    cmd_len = 4'd0;
  logic          cmd_ready;
  logic          j;
  logic          k;
  logic          busy;
  logic          done;
  logic          q_model;
  logic [LW-1:0] level;

  jk_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .flush     (flush),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .q_model   (q_model),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Reference JK flip-flop fed by the DUT's own j/k.
  logic ref_q;
  always @(posedge clk or posedge rst) begin
    if (rst) ref_q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   ref_q <= 1'b0;
        2'b10:   ref_q <= 1'b1;
        2'b11:   ref_q <= ~ref_q;
        default: ref_q <= ref_q;
      endcase
    end
  end

  // Behavioural model: pending commands, the active command and cycles left.
  logic [5:0] exp_q[$];
  bit         m_act;
  logic [1:0] m_op;
  int         m_rem;
  bit         m_done;
  bit         m_qm;
  bit         last_acc;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_done, cnt_set, cnt_tog, cnt_rst;
  bit saw_full;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit         acc;
    logic [1:0] cur;
    logic [5:0] c;
    acc = cmd_valid && (exp_q.size() < DEPTH) && !flush;
    cur = m_act ? m_op : 2'b00;
    case (cur)
      2'b01: m_qm = 1'b0;
      2'b10: m_qm = 1'b1;
      2'b11: m_qm = ~m_qm;
      default: ;
    endcase
    m_done = 1'b0;
    if (flush) begin
      exp_q.delete();
      m_act = 1'b0;
    end else begin
      if (m_act) begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1'b1;
          m_act  = 1'b0;
        end
      end
      if (!m_act && exp_q.size() > 0) begin
        c     = exp_q.pop_front();
        m_act = 1'b1;
        m_op  = c[5:4];
        m_rem = int'(c[3:0]) + 1;
      end
      if (acc) exp_q.push_back({cmd_op, cmd_len});
    end
    last_acc = acc;
  endtask

  task automatic check_outputs();
    logic [1:0] ejk;
    ejk = m_act ? m_op : 2'b00;
    check("j", 8'(j), 8'(ejk[1]));
    check("k", 8'(k), 8'(ejk[0]));
    check("busy", 8'(busy), 8'(m_act));
    check("done", 8'(done), 8'(m_done));
    check("q_model", 8'(q_model), 8'(m_qm));
    check("q_ref", 8'(q_model), 8'(ref_q));
    check("level", 8'(level), 8'(exp_q.size()));
    check("cmd_ready", 8'(cmd_ready), 8'((exp_q.size() < DEPTH) && !flush));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
    if (done) cnt_done++;
    if (j && !k) cnt_set++;
    if (j && k) cnt_tog++;
    if (!j && k) cnt_rst++;
    if (!cmd_ready) saw_full = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    for (int t = 0; t < 200; t++) begin
      cycle();
      if (last_acc) break;
    end
    check("send_accept", 8'(last_acc), 8'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic clear_counts();
    cnt_done = 0; cnt_set = 0; cnt_tog = 0; cnt_rst = 0; saw_full = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_act = 1'b0; m_done = 1'b0; m_qm = 1'b0; m_rem = 0; m_op = 2'b00; last_acc = 1'b0;
  endtask

  // Raise rst between edges and check outputs clear before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("arst_j", 8'(j), 8'd0);
    check("arst_k", 8'(k), 8'd0);
    check("arst_busy", 8'(busy), 8'd0);
    check("arst_done", 8'(done), 8'd0);
    check("arst_q", 8'(q_model), 8'd0);
    check("arst_level", 8'(level), 8'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic qf;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_level", 8'(level), 8'd0);
    check("rst_ready", 8'(cmd_ready), 8'd1);
    check("rst_q", 8'(q_model), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Single SET len=2.
    clear_counts();
    send(2'b10, 4'd2);
    idle(6);
    check("set_cycles", 8'(cnt_set), 8'd3);
    check("set_done", 8'(cnt_done), 8'd1);
    check("set_q", 8'(q_model), 8'd1);

    // TOGGLE len=3 then RESET len=0, back to back.
    do_reset();
    clear_counts();
    send(2'b11, 4'd3);
    send(2'b01, 4'd0);
    idle(8);
    check("tog_cycles", 8'(cnt_tog), 8'd4);
    check("rst_cycles", 8'(cnt_rst), 8'd1);
    check("tr_done", 8'(cnt_done), 8'd2);
    check("tr_q", 8'(q_model), 8'd0);

    // Overfill while a long command runs.
    clear_counts();
    send(2'b10, 4'd7);
    for (int i = 0; i < 5; i++) send(2'(i), 4'd1);
    idle(30);
    check("full_seen", 8'(saw_full), 8'd1);
    check("fill_done", 8'(cnt_done), 8'd6);

    // Flush during RUN with two queued.
    send(2'b11, 4'd9);
    send(2'b10, 4'd1);
    send(2'b01, 4'd1);
    cycle();
    clear_counts();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_busy", 8'(busy), 8'd0);
    check("flush_level", 8'(level), 8'd0);
    qf = q_model;
    idle(4);
    check("flush_qhold", 8'(q_model), 8'(qf));
    check("flush_done", 8'(cnt_done), 8'd0);

    // Reset in the middle of a long TOGGLE, then a fresh SET.
    send(2'b11, 4'd15);
    idle(4);
    do_reset();
    clear_counts();
    send(2'b10, 4'd0);
    idle(3);
    check("post_rst_set", 8'(cnt_set), 8'd1);
    check("post_rst_done", 8'(cnt_done), 8'd1);
    check("post_rst_q", 8'(q_model), 8'd1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        flush = 1'b0;
        do_reset();
      end
      if (!cmd_valid || last_acc) begin
        cmd_valid = ($urandom_range(0, 2) != 0);
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_len   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(0, 2));
      end
      flush = ($urandom_range(0, 24) == 0);
      cycle();
    end
    flush = 1'b0;
    cmd_valid = 1'b0;
    idle(40);
    check("final_idle", 8'(busy), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
